xadc_drp_reader: RTL

XADC_DRP_READER -- requirements
Module: xadc_drp_reader

---
 rtl/xadc_pkg.sv | 33 +++
 rtl/xadc_drp_reader_if.sv | 26 ++
 rtl/xadc_sample_fifo.sv | 56 +++++
 rtl/xadc_drp_reader.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/xadc_pkg.sv
// Shared types and constants for the XADC DRP sample reader.
package xadc_pkg;

  localparam int DRP_ADDR_W = 7;

  // Auxiliary analog inputs VAUX0..VAUX15 start at this DRP status address.
  localparam logic [DRP_ADDR_W-1:0] AUX_BASE_ADDR = 7'h10;

  typedef struct packed {
    logic [4:0]  chan;
    logic [11:0] value;
  } xadc_sample_t;

  localparam int SAMPLE_W = $bits(xadc_sample_t);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_PUSH
  } rd_state_t;

  // XADC status registers map one-to-one onto channel numbers.
  function automatic logic [DRP_ADDR_W-1:0] drp_addr_of(input logic [4:0] chan);
    return {2'b00, chan};
  endfunction

  // Event counters stick at 255 instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/xadc_drp_reader_if.sv
// DRP read port plus the valid/ready sample stream towards the AXI side.
interface xadc_drp_reader_if;
  import xadc_pkg::*;

  logic                  drp_den;
  logic                  drp_dwe;
  logic [DRP_ADDR_W-1:0] drp_daddr;
  logic                  drp_drdy;
  logic [15:0]           drp_do;

  logic                  s_valid;
  logic                  s_ready;
  xadc_sample_t          s_data;

  // Reader side: issues DRP reads and sources the sample stream.
  modport master (
    output drp_den, drp_dwe, drp_daddr, s_valid, s_data,
    input  drp_drdy, drp_do, s_ready
  );

  // XADC / consumer side.
  modport slave (
    input  drp_den, drp_dwe, drp_daddr, s_valid, s_data,
    output drp_drdy, drp_do, s_ready
  );
endinterface

// File: rtl/xadc_sample_fifo.sv
// Synchronous FIFO; a push into a full FIFO is accepted when a pop
// happens in the same cycle.
module xadc_sample_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW + 1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q];

  // Storage write.
  // NOTE: the array has no reset; emptiness is tracked by count_q alone, so
  // stale contents are never visible and the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  // NOTE: non-blocking assignments let every register sample the pre-edge
  // values regardless of statement order, matching real flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/xadc_drp_reader.sv
// Reads each converted XADC channel over DRP on end-of-conversion and queues
// {channel, sample} for the AXI register side. One eoc can be held pending
// while a read is in progress; further ones are counted as missed.
module xadc_drp_reader
  import xadc_pkg::*;
#(
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   eoc,
  input  logic [4:0]             channel,
  input  logic                   clr_cnt,
  output logic [7:0]             overflow_cnt,
  output logic [7:0]             missed_cnt,
  output logic [7:0]             timeout_cnt,
  xadc_drp_reader_if.master      bus
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  rd_state_t         state_q, state_d;
  logic [4:0]        chan_q, chan_d;
  logic [11:0]       sample_q, sample_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              pending_q, pending_d;
  logic [4:0]        pend_chan_q, pend_chan_d;
  logic [7:0]        overflow_q, missed_q, timeout_q;

  logic              push, pop, fifo_full, fifo_empty;
  logic              missed_inc, timeout_inc, overflow_inc;
  xadc_sample_t      push_data, pop_data;

  // Next-state, capture and pending-eoc bookkeeping.
  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    chan_d      = chan_q;
    sample_d    = sample_q;
    wait_d      = wait_q;
    pending_d   = pending_q;
    pend_chan_d = pend_chan_q;
    push        = 1'b0;
    missed_inc  = 1'b0;
    timeout_inc = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          // Older request first; a fresh eoc takes its place in the pending slot.
          state_d     = ST_REQ;
          chan_d      = pend_chan_q;
          pending_d   = eoc;
          pend_chan_d = eoc ? channel : pend_chan_q;
        end else if (eoc) begin
          state_d = ST_REQ;
          chan_d  = channel;
        end
      end
      ST_REQ: begin
        state_d = ST_WAIT;
        wait_d  = '0;
      end
      ST_WAIT: begin
        if (bus.drp_drdy) begin
          sample_d = bus.drp_do[15:4];
          state_d  = ST_PUSH;
        end else if (wait_q == WAIT_LAST) begin
          timeout_inc = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      ST_PUSH: begin
        push    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // eoc while busy: keep only the newest channel.
    if (eoc && (state_q != ST_IDLE)) begin
      missed_inc  = pending_q;
      pending_d   = 1'b1;
      pend_chan_d = channel;
    end
  end

  // FSM state and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      chan_q      <= '0;
      sample_q    <= '0;
      wait_q      <= '0;
      pending_q   <= 1'b0;
      pend_chan_q <= '0;
    end else begin
      state_q     <= state_d;
      chan_q      <= chan_d;
      sample_q    <= sample_d;
      wait_q      <= wait_d;
      pending_q   <= pending_d;
      pend_chan_q <= pend_chan_d;
    end
  end

  // Saturating event counters; clear wins over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= '0;
      missed_q   <= '0;
      timeout_q  <= '0;
    end else if (clr_cnt) begin
      overflow_q <= '0;
      missed_q   <= '0;
      timeout_q  <= '0;
    end else begin
      if (overflow_inc) overflow_q <= sat_inc(overflow_q);
      if (missed_inc)   missed_q   <= sat_inc(missed_q);
      if (timeout_inc)  timeout_q  <= sat_inc(timeout_q);
    end
  end

  assign pop          = bus.s_valid && bus.s_ready;
  assign overflow_inc = push && fifo_full && !pop;
  assign push_data    = '{chan: chan_q, value: sample_q};

  xadc_sample_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (SAMPLE_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (pop),
    .data_o  (pop_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Outputs decode straight from state so reset clears them immediately.
  assign bus.drp_den   = (state_q == ST_REQ);
  assign bus.drp_dwe   = 1'b0;
  assign bus.drp_daddr = (state_q == ST_REQ) ? drp_addr_of(chan_q) : '0;
  assign bus.s_valid   = !fifo_empty;
  assign bus.s_data    = pop_data;

  assign overflow_cnt  = overflow_q;
  assign missed_cnt    = missed_q;
  assign timeout_cnt   = timeout_q;

endmodule
